maxnet_ctrl: RTL and testbench

MAXNET_CTRL -- requirements
Module: maxnet_ctrl

---
 rtl/maxnet_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_maxnet_ctrl.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_ctrl.sv
// maxnet_ctrl -- sequencer for a four-neuron MAXNET winner-take-all network.
//
// One activation at a time is computed by an external PLU (multiply-accumulate).
// For neuron j, the PLU gets weight row w = {WINH.., WSELF at j, ..WINH} and the
// current activations a = act[0..3]. Its result is passed through a ReLU into
// nxt[j]. After all four neurons, nxt replaces act and the survivors are counted.
//
// Optional build macro:
//   MAXNET_CTRL_WATCHDOG_EN -- abort a PLU wait after 256 cycles with err=1.
//                              When undefined, err is tied low and WAIT never times out.
//
// Ports:
//   clk, rst (async, active-low)
//   go                  start request, sampled in IDLE only
//   x1..x4              signed initial activations, copied into act in LOAD
//   w1..w4, a1..a4      weight row and activations presented to the PLU
//   plu_start           one-cycle PLU start pulse (ISSUE)
//   plu_done, plu_out   PLU completion flag and signed result
//   busy                high outside IDLE
//   done                one-cycle completion pulse (FIN)
//   winner, none, limit, err, iter   result; held until the next LOAD
module maxnet_ctrl #(
  parameter logic signed [31:0] WSELF    = 32'sh0001_0000,
  parameter logic signed [31:0] WINH     = 32'shFFFF_C000,
  parameter int unsigned        MAX_ITER = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic signed [31:0] x1,
  input  logic signed [31:0] x2,
  input  logic signed [31:0] x3,
  input  logic signed [31:0] x4,
  output logic signed [31:0] w1,
  output logic signed [31:0] w2,
  output logic signed [31:0] w3,
  output logic signed [31:0] w4,
  output logic signed [31:0] a1,
  output logic signed [31:0] a2,
  output logic signed [31:0] a3,
  output logic signed [31:0] a4,
  output logic               plu_start,
  input  logic               plu_done,
  input  logic signed [31:0] plu_out,
  output logic               busy,
  output logic               done,
  output logic [1:0]         winner,
  output logic               none,
  output logic               limit,
  output logic               err,
  output logic [7:0]         iter
);

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT, S_CAPTURE, S_COMMIT, S_CHECK, S_FIN
  } state_t;

  state_t                   state, state_nxt;
  logic signed [DATA_W-1:0] act [4];
  logic signed [DATA_W-1:0] nxt [4];
  logic signed [DATA_W-1:0] w_vec [4];
  logic [1:0]               j;
  logic [2:0]               nz_cnt;
  logic [1:0]               nz_idx;
  logic [1:0]               max_idx;
  logic                     at_limit;
  logic                     wd_expire;

  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? '0 : v;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef MAXNET_CTRL_WATCHDOG_EN
  logic [7:0] wd_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                wd_cnt <= '0;
    else if (state == S_WAIT) wd_cnt <= wd_cnt + 8'd1;
    else                     wd_cnt <= '0;
  end

  // wd_cnt==255 marks the 256th WAIT cycle; a plu_done in that cycle still wins.
  assign wd_expire = (state == S_WAIT) && !plu_done && (wd_cnt == 8'hFF);
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  // Survivor scan used by CHECK; argmax keeps the lowest index on ties.
  always_comb begin
    nz_cnt  = '0;
    nz_idx  = '0;
    max_idx = '0;
    for (int k = 0; k < 4; k++) begin
      if (act[k] != '0) begin
        nz_cnt = nz_cnt + 3'd1;
        nz_idx = 2'(k);
      end
    end
    for (int k = 1; k < 4; k++) begin
      if (act[k] > act[max_idx]) max_idx = 2'(k);
    end
  end

  assign at_limit = (iter == 8'(MAX_ITER));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (go) state_nxt = S_LOAD;
      S_LOAD:    state_nxt = S_ISSUE;
      S_ISSUE:   state_nxt = S_WAIT;
      S_WAIT: begin
        if (plu_done)       state_nxt = S_CAPTURE;
        else if (wd_expire) state_nxt = S_FIN;
      end
      S_CAPTURE: state_nxt = (j == 2'd3) ? S_COMMIT : S_ISSUE;
      S_COMMIT:  state_nxt = S_CHECK;
      S_CHECK:   state_nxt = ((nz_cnt <= 3'd1) || at_limit) ? S_FIN : S_ISSUE;
      S_FIN:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    plu_start = (state == S_ISSUE);
    busy      = (state != S_IDLE);
    done      = (state == S_FIN);
    for (int k = 0; k < 4; k++) begin
      w_vec[k] = '0;
      if ((state == S_ISSUE) || (state == S_WAIT) || (state == S_CAPTURE))
        w_vec[k] = (2'(k) == j) ? WSELF : WINH;
    end
  end

  assign w1 = w_vec[0];
  assign w2 = w_vec[1];
  assign w3 = w_vec[2];
  assign w4 = w_vec[3];
  assign a1 = act[0];
  assign a2 = act[1];
  assign a3 = act[2];
  assign a4 = act[3];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        act[k] <= '0;
        nxt[k] <= '0;
      end
      j      <= '0;
      iter   <= '0;
      winner <= '0;
      none   <= 1'b0;
      limit  <= 1'b0;
`ifdef MAXNET_CTRL_WATCHDOG_EN
      err    <= 1'b0;
`endif
    end else begin
      case (state)
        S_LOAD: begin
          act[0] <= x1;
          act[1] <= x2;
          act[2] <= x3;
          act[3] <= x4;
          iter   <= '0;
          none   <= 1'b0;
          limit  <= 1'b0;
          j      <= '0;
`ifdef MAXNET_CTRL_WATCHDOG_EN
          err    <= 1'b0;
`endif
        end
`ifdef MAXNET_CTRL_WATCHDOG_EN
        S_WAIT: begin
          if (wd_expire) begin
            err    <= 1'b1;
            winner <= '0;
          end
        end
`endif
        S_CAPTURE: begin
          nxt[j] <= relu(plu_out);
          j      <= j + 2'd1;
        end
        S_COMMIT: begin
          for (int k = 0; k < 4; k++) act[k] <= nxt[k];
          iter <= sat_inc(iter);
        end
        S_CHECK: begin
          if (nz_cnt == 3'd1) begin
            winner <= nz_idx;
          end else if (nz_cnt == 3'd0) begin
            none   <= 1'b1;
            winner <= '0;
          end else if (at_limit) begin
            limit  <= 1'b1;
            winner <= max_idx;
          end else begin
            j <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_ctrl.sv
// Bench for maxnet_ctrl: two instances (MAX_ITER=16 and MAX_ITER=2) share clock,
// reset, go and x; each has its own Q16 multiply-accumulate PLU model with a
// 3-cycle latency. Expected results are queued when go is driven and popped
// when the done pulses arrive.
module tb_maxnet_ctrl;

  localparam logic signed [31:0] WSELF_TB = 32'sh0001_0000;
  localparam logic signed [31:0] WINH_TB  = 32'shFFFF_C000;

  typedef struct packed {
    logic [1:0] winner;
    logic       none;
    logic       limit;
    logic       err;
    logic [7:0] iter;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               go;
  logic signed [31:0] x [4];
  logic signed [31:0] w [2][4];
  logic signed [31:0] a [2][4];
  logic               plu_start [2];
  logic               plu_done [2] = '{1'b0, 1'b0};
  logic signed [31:0] plu_out [2]  = '{32'sd0, 32'sd0};
  logic               busy [2];
  logic               done [2];
  logic [1:0]         winner [2];
  logic               none [2];
  logic               limit [2];
  logic               err [2];
  logic [7:0]         iter [2];

  int                 vectors = 0;
  int                 miscompares = 0;
  bit                 plu_en = 1'b1;
  int                 pcnt [2] = '{0, 0};
  logic signed [31:0] pres [2] = '{32'sd0, 32'sd0};
  logic signed [31:0] wl [4];
  logic signed [31:0] al [4];
  exp_t               q0 [$];
  exp_t               q1 [$];

  always #5 clk = ~clk;

  maxnet_ctrl u_dut (
    .clk(clk), .rst(rst), .go(go),
    .x1(x[0]), .x2(x[1]), .x3(x[2]), .x4(x[3]),
    .w1(w[0][0]), .w2(w[0][1]), .w3(w[0][2]), .w4(w[0][3]),
    .a1(a[0][0]), .a2(a[0][1]), .a3(a[0][2]), .a4(a[0][3]),
    .plu_start(plu_start[0]), .plu_done(plu_done[0]), .plu_out(plu_out[0]),
    .busy(busy[0]), .done(done[0]), .winner(winner[0]),
    .none(none[0]), .limit(limit[0]), .err(err[0]), .iter(iter[0])
  );

  maxnet_ctrl #(.MAX_ITER(2)) u_lim (
    .clk(clk), .rst(rst), .go(go),
    .x1(x[0]), .x2(x[1]), .x3(x[2]), .x4(x[3]),
    .w1(w[1][0]), .w2(w[1][1]), .w3(w[1][2]), .w4(w[1][3]),
    .a1(a[1][0]), .a2(a[1][1]), .a3(a[1][2]), .a4(a[1][3]),
    .plu_start(plu_start[1]), .plu_done(plu_done[1]), .plu_out(plu_out[1]),
    .busy(busy[1]), .done(done[1]), .winner(winner[1]),
    .none(none[1]), .limit(limit[1]), .err(err[1]), .iter(iter[1])
  );

  function automatic logic signed [31:0] plu_mac(input logic signed [31:0] wv [4],
                                                 input logic signed [31:0] av [4]);
    longint acc;
    acc = 0;
    for (int i = 0; i < 4; i++) acc += longint'(wv[i]) * longint'(av[i]);
    acc = acc >>> 16;
    return acc[31:0];
  endfunction

  // PLU model: latch operands on plu_start, answer with a one-cycle plu_done 3 cycles later.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      plu_done[d] = 1'b0;
      if (pcnt[d] > 0) begin
        pcnt[d] = pcnt[d] - 1;
        if (pcnt[d] == 0) begin
          plu_done[d] = 1'b1;
          plu_out[d]  = pres[d];
        end
      end
      if (plu_start[d] && plu_en) begin
        for (int k = 0; k < 4; k++) begin
          wl[k] = w[d][k];
          al[k] = a[d][k];
        end
        pres[d] = plu_mac(wl, al);
        pcnt[d] = 3;
      end
    end
  end

  function automatic exp_t mk(input logic [1:0] wn, input logic nn, input logic lm,
                              input logic er, input logic [7:0] it);
    return {wn, nn, lm, er, it};
  endfunction

  // Reference competition built from the network definition.
  function automatic exp_t ref_run(input logic signed [31:0] x0, input logic signed [31:0] x1,
                                   input logic signed [31:0] x2, input logic signed [31:0] x3,
                                   input int mi);
    logic signed [31:0] ac [4];
    logic signed [31:0] nx [4];
    logic signed [31:0] wr [4];
    exp_t r;
    int it, cnt, idx, mx;
    ac[0] = x0; ac[1] = x1; ac[2] = x2; ac[3] = x3;
    r = '0;
    it = 0;
    for (int g = 0; g < 300; g++) begin
      for (int jj = 0; jj < 4; jj++) begin
        for (int i = 0; i < 4; i++) wr[i] = (i == jj) ? WSELF_TB : WINH_TB;
        nx[jj] = plu_mac(wr, ac);
        if (nx[jj] < 0) nx[jj] = 0;
      end
      ac = nx;
      it = (it < 255) ? it + 1 : 255;
      cnt = 0; idx = 0; mx = 0;
      for (int i = 0; i < 4; i++) if (ac[i] != 0) begin cnt++; idx = i; end
      for (int i = 1; i < 4; i++) if (ac[i] > ac[mx]) mx = i;
      r.iter = 8'(it);
      if (cnt == 1) begin r.winner = 2'(idx); return r; end
      if (cnt == 0) begin r.none = 1'b1; r.winner = 2'd0; return r; end
      if (it == mi) begin r.limit = 1'b1; r.winner = 2'(mx); return r; end
    end
    return r;
  endfunction

  task automatic start(input logic signed [31:0] x0, input logic signed [31:0] x1,
                       input logic signed [31:0] x2, input logic signed [31:0] x3,
                       input exp_t e0, input exp_t e1, input bit push);
    @(negedge clk); #1;
    x[0] = x0; x[1] = x1; x[2] = x2; x[3] = x3;
    go = 1'b1;
    if (push) begin
      q0.push_back(e0);
      q1.push_back(e1);
    end
    @(negedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n0, output int n1);
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (done[0]) n0++;
      if (done[1]) n1++;
      if (n0 > 0 && n1 > 0 && !done[0] && !done[1]) break;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({busy[d], done[d], plu_start[d], winner[d], none[d], limit[d], err[d], iter[d]} !== '0) begin
        miscompares++;
        $display("FAIL reset_ctrl[%0d] got %h want 0", d,
                 {busy[d], done[d], plu_start[d], winner[d], none[d], limit[d], err[d], iter[d]});
      end
      vectors++;
      if ({w[d][0], w[d][1], w[d][2], w[d][3], a[d][0], a[d][1], a[d][2], a[d][3]} !== '0) begin
        miscompares++;
        $display("FAIL reset_data[%0d] got %h want 0", d,
                 {w[d][0], w[d][1], w[d][2], w[d][3], a[d][0], a[d][1], a[d][2], a[d][3]});
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_single_winner;
    int nd [2];
    exp_t e, o;
    start(32'sd0, 32'sd0, 32'sh0005_0000, 32'sd0, mk(2'd2, 1'b0, 1'b0, 1'b0, 8'd1),
          mk(2'd2, 1'b0, 1'b0, 1'b0, 8'd1), 1'b1);
    // A go while busy must not restart the run with these new inputs.
    repeat (3) @(negedge clk);
    #1;
    x[0] = 32'sd0; x[1] = 32'sd0; x[2] = 32'sd0; x[3] = 32'sd0;
    go = 1'b1;
    @(negedge clk); #1;
    go = 1'b0;
    wait_done(2000, nd[0], nd[1]);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
      o = {winner[d], none[d], limit[d], err[d], iter[d]};
      vectors++;
      if (nd[d] != 1) begin miscompares++; $display("FAIL single_winner done_pulses[%0d] got %0d want 1", d, nd[d]); end
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL single_winner result[%0d] got %h want %h", d, o, e); end
    end
  endtask

  task automatic test_all_zero;
    int nd [2];
    exp_t e, o;
    start(32'sd0, 32'sd0, 32'sd0, 32'sd0, mk(2'd0, 1'b1, 1'b0, 1'b0, 8'd1),
          mk(2'd0, 1'b1, 1'b0, 1'b0, 8'd1), 1'b1);
    wait_done(2000, nd[0], nd[1]);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
      o = {winner[d], none[d], limit[d], err[d], iter[d]};
      vectors++;
      if (nd[d] != 1) begin miscompares++; $display("FAIL all_zero done_pulses[%0d] got %0d want 1", d, nd[d]); end
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL all_zero result[%0d] got %h want %h", d, o, e); end
    end
  endtask

  task automatic test_limit;
    int nd [2];
    exp_t e, o;
    // Equal inputs shrink by 4x per iteration: MAX_ITER=16 dies out at iteration 9,
    // MAX_ITER=2 stops at the limit with all four at 0x1000.
    start(32'sh0001_0000, 32'sh0001_0000, 32'sh0001_0000, 32'sh0001_0000,
          mk(2'd0, 1'b1, 1'b0, 1'b0, 8'd9), mk(2'd0, 1'b0, 1'b1, 1'b0, 8'd2), 1'b1);
    wait_done(3000, nd[0], nd[1]);
    for (int d = 0; d < 2; d++) begin
      if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
      o = {winner[d], none[d], limit[d], err[d], iter[d]};
      vectors++;
      if (nd[d] != 1) begin miscompares++; $display("FAIL limit done_pulses[%0d] got %0d want 1", d, nd[d]); end
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL limit result[%0d] got %h want %h", d, o, e); end
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (a[1][k] !== 32'sh0000_1000) begin
        miscompares++;
        $display("FAIL limit act[%0d] got %h want 00001000", k, a[1][k]);
      end
    end
  endtask

  task automatic test_issue_hold;
    int nd [2];
    int nst;
    bit prev_st, track, cap_next;
    logic signed [31:0] sw [4];
    logic signed [31:0] sa [4];
    logic signed [31:0] ew [4];
    exp_t e, o;
    nst = 0; prev_st = 1'b0; track = 1'b0; cap_next = 1'b0;
    nd[0] = 0; nd[1] = 0;
    start(32'sh0004_0000, 32'sh0003_0000, 32'sd0, 32'sd0, mk(2'd0, 1'b0, 1'b0, 1'b0, 8'd4),
          mk(2'd0, 1'b0, 1'b1, 1'b0, 8'd2), 1'b1);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (plu_start[0]) begin
        vectors++;
        if (prev_st) begin miscompares++; $display("FAIL issue_pulse cycle %0d plu_start got 1 want 0", c); end
        for (int k = 0; k < 4; k++) ew[k] = (k == nst % 4) ? WSELF_TB : WINH_TB;
        vectors++;
        if ({w[0][0], w[0][1], w[0][2], w[0][3]} !== {ew[0], ew[1], ew[2], ew[3]}) begin
          miscompares++;
          $display("FAIL issue_weights neuron %0d got %h want %h", nst % 4,
                   {w[0][0], w[0][1], w[0][2], w[0][3]}, {ew[0], ew[1], ew[2], ew[3]});
        end
        for (int k = 0; k < 4; k++) begin
          sw[k] = w[0][k];
          sa[k] = a[0][k];
        end
        track = 1'b1;
        cap_next = 1'b0;
        nst++;
      end else if (track) begin
        vectors++;
        if ({w[0][0], w[0][1], w[0][2], w[0][3], a[0][0], a[0][1], a[0][2], a[0][3]} !==
            {sw[0], sw[1], sw[2], sw[3], sa[0], sa[1], sa[2], sa[3]}) begin
          miscompares++;
          $display("FAIL issue_hold cycle %0d w/a got %h want %h", c,
                   {w[0][0], w[0][1], w[0][2], w[0][3], a[0][0], a[0][1], a[0][2], a[0][3]},
                   {sw[0], sw[1], sw[2], sw[3], sa[0], sa[1], sa[2], sa[3]});
        end
        if (cap_next) track = 1'b0;
        else if (plu_done[0]) cap_next = 1'b1;
      end
      prev_st = plu_start[0];
      if (done[0]) nd[0]++;
      if (done[1]) nd[1]++;
      if (nd[0] > 0 && nd[1] > 0 && !done[0] && !done[1]) break;
    end
    vectors++;
    if (nst != 16) begin miscompares++; $display("FAIL issue_count got %0d want 16", nst); end
    for (int d = 0; d < 2; d++) begin
      if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
      o = {winner[d], none[d], limit[d], err[d], iter[d]};
      vectors++;
      if (nd[d] != 1) begin miscompares++; $display("FAIL issue_hold done_pulses[%0d] got %0d want 1", d, nd[d]); end
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL issue_hold result[%0d] got %h want %h", d, o, e); end
    end
  endtask

  task automatic test_reset_mid_wait;
    int ns, nd, nb;
    bit hit, late;
    ns = 0; hit = 1'b0; nd = 0; nb = 0; late = 1'b0;
    start(32'sd0, 32'sd0, 32'sh0005_0000, 32'sd0, '0, '0, 1'b0);
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (plu_start[0]) ns++;
      if (ns == 2 && !plu_start[0]) begin hit = 1'b1; break; end
    end
    vectors++;
    if (!hit) begin miscompares++; $display("FAIL reset_wait second WAIT reached got 0 want 1"); end
    rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({busy[d], done[d], plu_start[d], winner[d], none[d], limit[d], err[d], iter[d]} !== '0) begin
        miscompares++;
        $display("FAIL reset_wait_ctrl[%0d] got %h want 0", d,
                 {busy[d], done[d], plu_start[d], winner[d], none[d], limit[d], err[d], iter[d]});
      end
      vectors++;
      if ({w[d][0], w[d][1], w[d][2], w[d][3], a[d][0], a[d][1], a[d][2], a[d][3]} !== '0) begin
        miscompares++;
        $display("FAIL reset_wait_data[%0d] got %h want 0", d,
                 {w[d][0], w[d][1], w[d][2], w[d][3], a[d][0], a[d][1], a[d][2], a[d][3]});
      end
    end
    @(negedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      if (plu_done[0]) late = 1'b1;
      if (done[0] || done[1]) nd++;
      if (busy[0] || busy[1]) nb++;
    end
    vectors++;
    if (nd != 0) begin miscompares++; $display("FAIL reset_wait done_pulses got %0d want 0 (late plu_done seen=%0d)", nd, late); end
    vectors++;
    if (nb != 0) begin miscompares++; $display("FAIL reset_wait busy_cycles got %0d want 0", nb); end
  endtask

  task automatic test_random;
    int nd [2];
    exp_t e, o, e0, e1;
    logic signed [31:0] xr [4];
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 3; k++) xr[k] = 32'($urandom_range(0, 32'h0006_0000));
      xr[3] = 32'($urandom_range(0, 32'h0004_0000)) - 32'sh0002_0000;
      e0 = ref_run(xr[0], xr[1], xr[2], xr[3], 16);
      e1 = ref_run(xr[0], xr[1], xr[2], xr[3], 2);
      start(xr[0], xr[1], xr[2], xr[3], e0, e1, 1'b1);
      wait_done(3000, nd[0], nd[1]);
      for (int d = 0; d < 2; d++) begin
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        o = {winner[d], none[d], limit[d], err[d], iter[d]};
        vectors++;
        if (nd[d] != 1) begin miscompares++; $display("FAIL random%0d done_pulses[%0d] got %0d want 1", t, d, nd[d]); end
        vectors++;
        if (o !== e) begin miscompares++; $display("FAIL random%0d result[%0d] got %h want %h", t, d, o, e); end
      end
    end
  endtask

  task automatic test_watchdog;
    int nd [2];
    plu_en = 1'b0;
`ifdef MAXNET_CTRL_WATCHDOG_EN
    begin
      int first, dcyc;
      exp_t e, o;
      first = -1; dcyc = -1; nd[0] = 0; nd[1] = 0;
      start(32'sh0001_0000, 32'sd0, 32'sd0, 32'sd0, mk(2'd0, 1'b0, 1'b0, 1'b1, 8'd0),
            mk(2'd0, 1'b0, 1'b0, 1'b1, 8'd0), 1'b1);
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk); #1;
        if (plu_start[0] && first < 0) first = c;
        if (done[0] && dcyc < 0) dcyc = c;
        if (done[0]) nd[0]++;
        if (done[1]) nd[1]++;
        if (nd[0] > 0 && nd[1] > 0 && !done[0] && !done[1]) break;
      end
      vectors++;
      if (dcyc - first != 257) begin
        miscompares++;
        $display("FAIL watchdog_delay issue-to-done got %0d want 257", dcyc - first);
      end
      for (int d = 0; d < 2; d++) begin
        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
        o = {winner[d], none[d], limit[d], err[d], iter[d]};
        vectors++;
        if (nd[d] != 1) begin miscompares++; $display("FAIL watchdog done_pulses[%0d] got %0d want 1", d, nd[d]); end
        vectors++;
        if (o !== e) begin miscompares++; $display("FAIL watchdog result[%0d] got %h want %h", d, o, e); end
      end
    end
`else
    start(32'sh0001_0000, 32'sd0, 32'sd0, 32'sd0, '0, '0, 1'b0);
    nd[0] = 0; nd[1] = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #1;
      if (done[0]) nd[0]++;
      if (done[1]) nd[1]++;
    end
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (nd[d] != 0) begin miscompares++; $display("FAIL no_watchdog done_pulses[%0d] got %0d want 0", d, nd[d]); end
      vectors++;
      if (busy[d] !== 1'b1) begin miscompares++; $display("FAIL no_watchdog busy[%0d] got %b want 1", d, busy[d]); end
      vectors++;
      if (err[d] !== 1'b0) begin miscompares++; $display("FAIL no_watchdog err[%0d] got %b want 0", d, err[d]); end
    end
    rst = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
`endif
    plu_en = 1'b1;
  endtask

  initial begin
    go = 1'b0;
    x[0] = 32'sd0; x[1] = 32'sd0; x[2] = 32'sd0; x[3] = 32'sd0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    test_reset;
    test_single_winner;
    test_all_zero;
    test_limit;
    test_issue_hold;
    test_reset_mid_wait;
    test_single_winner;
    test_random;
    test_watchdog;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout simulation still running at %0t want finished", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
